// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word and RAM handshake state reported to the bus controller.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Memory-side controller types: sequencer states and the latched request record.
package diaosi_types_pkg;

    typedef enum logic [1:0] {
        RC_IDLE,
        RC_WAIT,
        RC_ACCESS
    } ram_ctrl_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } ram_op_t;

    typedef struct packed {
        ram_op_t              op;
        cpu_types_pkg::word_t addr;
        logic [3:0]           cnt;
    } ram_req_t;

endpackage

// File: rtl/ram_array.sv
// DEPTH x 32 word storage: asynchronous read, synchronous write, contents never reset.
module ram_array
    import cpu_types_pkg::*;
#(
    parameter int unsigned DEPTH = 4096
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] addr_i,
    input  word_t                    wdata_i,
    output word_t                    rdata_o
);

    word_t mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ram_access_ctrl.sv
// Single-word RAM access sequencer with fixed latency LAT; owns main-memory storage.
// Optional RAM_BOUNDS_CHECK_EN reports misaligned/out-of-range requests as ERROR.
module ram_access_ctrl
    import cpu_types_pkg::*;
    import diaosi_types_pkg::*;
#(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 4096
) (
    input  logic      CLK,
    input  logic      nRST,
    input  logic      ramREN,
    input  logic      ramWEN,
    input  word_t     ramaddr,
    input  word_t     ramstore,
    output word_t     ramload,
    output ramstate_t ramstate
);

    localparam int unsigned IDXW   = $clog2(DEPTH);
    localparam logic [3:0]  LAT_M1 = 4'(LAT - 1);

    ram_ctrl_state_t state_q, state_d;
    ram_req_t        req_q, req_d;

    logic    req_present;
    logic    req_conflict;
    logic    addr_bad;
    logic    req_changed;
    logic    in_access;
    logic    mem_we;
    ram_op_t cur_op;
    word_t   mem_rdata;

    assign req_present  = ramREN ^ ramWEN;
    assign req_conflict = ramREN & ramWEN;
    assign cur_op       = ramWEN ? OP_WRITE : OP_READ;

`ifdef RAM_BOUNDS_CHECK_EN
    assign addr_bad = (ramaddr[1:0] != 2'b00) ||
                      ({32'b0, ramaddr} >= (64'(DEPTH) * 64'd4));
`else
    assign addr_bad = 1'b0;
`endif

    // Any deviation from the latched request aborts the access and is handled as if from idle.
    assign req_changed = (state_q != RC_IDLE) &&
                         (!req_present || (cur_op != req_q.op) || (ramaddr != req_q.addr));
    assign in_access   = (state_q == RC_ACCESS) && !req_changed;

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        ramstate = FREE;
        mem_we   = 1'b0;
        if ((state_q == RC_IDLE) || req_changed) begin
            state_d = RC_IDLE;
            if (req_conflict || (req_present && addr_bad)) begin
                ramstate = ERROR;
            end else if (req_present) begin
                ramstate   = BUSY;
                req_d.op   = cur_op;
                req_d.addr = ramaddr;
                req_d.cnt  = 4'd1;
                state_d    = (LAT == 1) ? RC_ACCESS : RC_WAIT;
            end
        end else if (state_q == RC_WAIT) begin
            ramstate  = BUSY;
            req_d.cnt = req_q.cnt + 4'd1;
            if (req_q.cnt == LAT_M1) begin
                state_d = RC_ACCESS;
            end
        end else begin
            ramstate = ACCESS;
            mem_we   = (req_q.op == OP_WRITE);
            state_d  = RC_IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RC_IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    ram_array #(
        .DEPTH (DEPTH)
    ) u_ram_array (
        .clk_i   (CLK),
        .we_i    (mem_we),
        .addr_i  (req_q.addr[IDXW+1:2]),
        .wdata_i (ramstore),
        .rdata_o (mem_rdata)
    );

    assign ramload = (in_access && (req_q.op == OP_READ)) ? mem_rdata : '0;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Randomized bench for ram_access_ctrl against a request-age reference model.
module tb_ram_access_ctrl;
    import cpu_types_pkg::*;

    localparam int unsigned LAT   = 2;
    localparam int unsigned DEPTH = 4096;

    logic      CLK;
    logic      nRST;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;

    ram_access_ctrl #(
        .LAT   (LAT),
        .DEPTH (DEPTH)
    ) dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: words known to have been written, and how long the current request has been held.
    logic [31:0] mem_model [int unsigned];
    int unsigned age        = 0;
    logic        prev_valid = 1'b0;
    logic        prev_wr    = 1'b0;
    logic [31:0] prev_addr  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic addr_is_bad(input logic [31:0] a);
`ifdef RAM_BOUNDS_CHECK_EN
        return (a % 4 != 0) || (64'(a) >= 64'(DEPTH) * 4);
`else
        return 1'b0;
`endif
    endfunction

    function automatic int unsigned word_idx(input logic [31:0] a);
        return (a / 4) % DEPTH;
    endfunction

    // One clock cycle: drive after the edge, check mid-cycle, advance the model for the coming edge.
    task automatic do_cycle(input logic ren, input logic wen, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
        ramstate_t   exp_st;
        logic        valid;
        logic        bad;
        int unsigned idx;
        ramREN   = ren;
        ramWEN   = wen;
        ramaddr  = a;
        ramstore = d;
        @(negedge CLK);
        valid = ren ^ wen;
        bad   = valid && addr_is_bad(a);
        idx   = word_idx(a);
        if (ren && wen)       exp_st = ERROR;
        else if (!valid)      exp_st = FREE;
        else if (bad)         exp_st = ERROR;
        else begin
            if (prev_valid && prev_wr == wen && prev_addr == a) age++;
            else age = 0;
            exp_st = (age % (LAT + 1) == LAT) ? ACCESS : BUSY;
        end
        prev_valid = valid && !bad;
        prev_wr    = wen;
        prev_addr  = a;
        check_eq({tag, ".state"}, 32'(ramstate), 32'(exp_st));
        if (exp_st == ACCESS && !wen) begin
            if (mem_model.exists(idx)) check_eq({tag, ".load"}, ramload, mem_model[idx]);
        end else begin
            check_eq({tag, ".load0"}, ramload, 32'h0);
        end
        if (exp_st == ACCESS && wen) mem_model[idx] = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic hold_req(input logic ren, input logic wen, input logic [31:0] a,
                            input logic [31:0] d, input int unsigned n, input string tag);
        for (int unsigned i = 0; i < n; i++) do_cycle(ren, wen, a, d, tag);
    endtask

    logic [31:0] addr_pool [7];
    int unsigned kind;
    int unsigned hold;
    logic [31:0] ra;
    logic [31:0] rd;

    initial begin
        addr_pool[0] = 32'h0000_0000;
        addr_pool[1] = 32'h0000_0004;
        addr_pool[2] = 32'h0000_0040;
        addr_pool[3] = 32'h0000_0044;
        addr_pool[4] = 32'h0000_0080;
        addr_pool[5] = 32'h0000_4000;
        addr_pool[6] = 32'h0000_0042;

        nRST = 1'b0; ramREN = 1'b0; ramWEN = 1'b0; ramaddr = '0; ramstore = '0;
        @(posedge CLK); @(posedge CLK); #2;
        check_eq("reset.state", 32'(ramstate), 32'(FREE));
        check_eq("reset.load", ramload, 32'h0);
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;

        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, "idle");
        hold_req(1'b1, 1'b1, 32'h40, 32'h5555_0000, 2, "conflict");

        hold_req(1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, LAT + 1, "wr40");
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, "gap");
        hold_req(1'b1, 1'b0, 32'h40, 32'h0, LAT + 1, "rd40");

        hold_req(1'b0, 1'b1, 32'h44, 32'h4444_4444, LAT + 1, "wr44");
        hold_req(1'b1, 1'b0, 32'h40, 32'h0, LAT + 1, "chain40");
        hold_req(1'b1, 1'b0, 32'h44, 32'h0, LAT + 1, "chain44");

        hold_req(1'b0, 1'b1, 32'h80, 32'h8080_8080, LAT + 1, "wr80");
        hold_req(1'b0, 1'b1, 32'h80, 32'hBAD0_BAD0, 2, "wr80drop");
        do_cycle(1'b0, 1'b0, 32'h0, 32'h0, "dropfree");
        hold_req(1'b1, 1'b0, 32'h80, 32'h0, LAT + 1, "rd80");

        do_cycle(1'b1, 1'b0, 32'h40, 32'h0, "chgA");
        hold_req(1'b1, 1'b0, 32'h44, 32'h0, LAT + 1, "chgB");

        hold_req(1'b0, 1'b1, 32'h10, 32'hAAAA_5555, LAT + 1, "wr10old");
        do_cycle(1'b0, 1'b1, 32'h10, 32'h0000_1234, "wr10c0");
        ramREN = 1'b0; ramWEN = 1'b1; ramaddr = 32'h10; ramstore = 32'h0000_1234;
        #2;
        check_eq("rst_mid.busy", 32'(ramstate), 32'(BUSY));
        nRST = 1'b0; ramWEN = 1'b0;
        #1;
        check_eq("rst_mid.state", 32'(ramstate), 32'(FREE));
        check_eq("rst_mid.load", ramload, 32'h0);
        @(negedge CLK); nRST = 1'b1;
        @(posedge CLK); #1;
        prev_valid = 1'b0;
        age        = 0;
        hold_req(1'b1, 1'b0, 32'h10, 32'h0, LAT + 1, "rd10");

        hold_req(1'b0, 1'b1, 32'h0, 32'h0BAD_F00D, LAT + 1, "wr0");
        hold_req(1'b1, 1'b0, 32'h4000, 32'h0, LAT + 2, "rd4000");
        hold_req(1'b1, 1'b0, 32'h42, 32'h0, LAT + 2, "rd42");

        for (int t = 0; t < 150; t++) begin
            kind = $urandom_range(0, 9);
            hold = $urandom_range(1, 2 * LAT + 3);
            ra   = addr_pool[$urandom_range(0, 6)];
            rd   = $urandom;
            if (kind == 0)      hold_req(1'b0, 1'b0, ra, rd, hold, "rnd.idle");
            else if (kind == 1) hold_req(1'b1, 1'b1, ra, rd, hold, "rnd.conf");
            else if (kind < 6)  hold_req(1'b1, 1'b0, ra, rd, hold, "rnd.rd");
            else                hold_req(1'b0, 1'b1, ra, rd, hold, "rnd.wr");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
